led_chaser: RTL and testbench

LED_CHASER -- requirements
Module: led_chaser

---
 rtl/led_chaser.sv | 135 +++++++++++++
 tb/tb_led_chaser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// led_chaser: LED pattern generator with four key-selectable modes and a
// programmable step rate. Each distinct non-zero key press advances the mode
// and restarts the pattern from the leftmost LED.
//
//   mode    | meaning
//   --------+-----------------------------------------------------------
//   SHIFT_R | single lit LED walks right, wrapping bit 0 -> leftmost
//   SHIFT_L | single lit LED walks left, wrapping leftmost -> bit 0
//   BOUNCE  | single lit LED walks back and forth, one tick at each end
//   FILL    | bar grows from the left, then all-off, then restarts
module led_chaser #(
    parameter int N_LEDS  = 8,
    parameter int DIV_MAX = 2000000,
    parameter int KEY_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_code,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] led,
    output logic [1:0]        mode
);

    localparam int CNT_W = $clog2(DIV_MAX + 1);
    localparam logic [CNT_W-1:0]  DIV_V  = CNT_W'(DIV_MAX);
    localparam logic [N_LEDS-1:0] MSB_1H = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] ALL_1  = '1;

    typedef enum logic [1:0] {
        SHIFT_R = 2'd0,
        SHIFT_L = 2'd1,
        BOUNCE  = 2'd2,
        FILL    = 2'd3
    } mode_t;

    mode_t             mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period;
    logic              tick;
    logic [KEY_W-1:0]  key_q;
    logic              key_evt;
    logic              dir_left;
    logic              is_one_hot;
    logic              is_bar;
    logic [N_LEDS-1:0] led_inv;
    logic [N_LEDS-1:0] led_next;
    logic              dir_next;
    logic              dir_eff;

    assign mode = mode_q;

    // Step period follows speed live; a counter already past the new limit ticks at once.
    always_comb begin
        period  = DIV_V >> speed;
        tick    = (cnt >= (period - CNT_W'(1)));
        key_evt = (key_code != key_q) && (key_code != '0);
    end

    // Pattern legality: one-hot for walking modes, left-aligned bar (or zero) for FILL.
    always_comb begin
        led_inv    = ~led;
        is_one_hot = (led != '0) && ((led & (led - N_LEDS'(1))) == '0);
        is_bar     = ((led_inv & (led_inv + N_LEDS'(1))) == '0);
    end

    // Next pattern and bounce direction for a tick; illegal patterns recover to MSB one-hot.
    always_comb begin
        led_next = MSB_1H;
        dir_next = 1'b0;
        dir_eff  = dir_left;
        case (mode_q)
            SHIFT_R: begin
                if (is_one_hot) led_next = {led[0], led[N_LEDS-1:1]};
            end
            SHIFT_L: begin
                if (is_one_hot) led_next = {led[N_LEDS-2:0], led[N_LEDS-1]};
            end
            BOUNCE: begin
                if (is_one_hot) begin
                    // An LED sitting at an end always heads back inward.
                    if (led[0])             dir_eff = 1'b1;
                    else if (led[N_LEDS-1]) dir_eff = 1'b0;
                    led_next = dir_eff ? (led << 1) : (led >> 1);
                    if (led_next[0])             dir_next = 1'b1;
                    else if (led_next[N_LEDS-1]) dir_next = 1'b0;
                    else                         dir_next = dir_eff;
                end
            end
            FILL: begin
                if (led == ALL_1)  led_next = '0;
                else if (is_bar)   led_next = (led >> 1) | MSB_1H;
            end
            default: begin
                led_next = MSB_1H;
            end
        endcase
    end

    // Step counter: cleared by a tick or by a key event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (key_evt || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Key history for press detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else begin
            key_q <= key_code;
        end
    end

    // Mode FSM and LED pattern; a key event wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= SHIFT_R;
            led      <= MSB_1H;
            dir_left <= 1'b0;
        end else if (key_evt) begin
            mode_q   <= mode_t'(mode_q + 2'd1);
            led      <= MSB_1H;
            dir_left <= 1'b0;
        end else if (tick) begin
            led      <= led_next;
            dir_left <= dir_next;
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser (N_LEDS=4, DIV_MAX=8). Stimulus pushes the expected
// {mode, led, cycle} of every output change; the monitor pops one entry per
// observed change and compares value and timing.
module tb_led_chaser;

    localparam int N  = 4;
    localparam int DM = 8;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [KW-1:0] key_code = '0;
    logic [1:0]    speed = 2'd0;
    logic [N-1:0]  led;
    logic [1:0]    mode;

    led_chaser #(.N_LEDS(N), .DIV_MAX(DM), .KEY_W(KW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_code (key_code),
        .speed    (speed),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0]   m;
        logic [N-1:0] l;
        int           t;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;
    logic [1:0]   prev_m = '0;
    logic [N-1:0] prev_l = '0;

    // Monitor: every change of {mode, led} must match the next expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && ({mode, led} !== {prev_m, prev_l})) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got mode=%0d led=%b at cycle %0d, required no change",
                         mode, led, cyc);
            end else begin
                e = exp_q.pop_front();
                if (mode !== e.m || led !== e.l || cyc != e.t) begin
                    errors++;
                    $display("FAIL step: got mode=%0d led=%b cycle=%0d, required mode=%0d led=%b cycle=%0d",
                             mode, led, cyc, e.m, e.l, e.t);
                end
            end
        end
        prev_m = mode;
        prev_l = led;
    end

    task automatic push(input logic [1:0] m, input logic [N-1:0] l, input int t);
        exp_t e;
        e.m = m;
        e.l = l;
        e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected changes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Asserts reset between clock edges, checks outputs before any edge arrives,
    // then releases on a falling edge and returns the cycle count at release.
    task automatic do_reset(input string name, output int r);
        check_drained({name, "_drain"});
        mon_en   = 1'b0;
        key_code = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b1000) begin
            errors++;
            $display("FAIL %s_led: got %b, required 1000", name, led);
        end
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL %s_mode: got %0d, required 0", name, mode);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        r      = cyc;
        mon_en = 1'b1;
    endtask

    initial begin : stim
        int r;
        int c;

        // Power-up reset, then free-running SHIFT_R at speed 0.
        do_reset("reset0", r);
        push(2'd0, 4'b0100, r + 8);
        push(2'd0, 4'b0010, r + 16);
        push(2'd0, 4'b0001, r + 24);
        push(2'd0, 4'b1000, r + 32);
        wait_to(r + 34);

        // Single held key: one mode advance, restart, then SHIFT_L wrap.
        c = cyc;
        key_code = 8'h15;
        push(2'd1, 4'b1000, c + 1);
        push(2'd1, 4'b0001, c + 9);
        push(2'd1, 4'b0010, c + 17);
        wait_to(c + 20);

        // Press/release sequence: releases ignored, three events -> FILL.
        do_reset("reset1", r);
        wait_to(r + 1); key_code = 8'h15; push(2'd1, 4'b1000, r + 2);
        wait_to(r + 3); key_code = 8'h00;
        wait_to(r + 5); key_code = 8'h15; push(2'd2, 4'b1000, r + 6);
        wait_to(r + 7); key_code = 8'h00;
        wait_to(r + 9); key_code = 8'h16; push(2'd3, 4'b1000, r + 10);
        push(2'd3, 4'b1100, r + 18);
        push(2'd3, 4'b1110, r + 26);
        push(2'd3, 4'b1111, r + 34);
        push(2'd3, 4'b0000, r + 42);
        push(2'd3, 4'b1000, r + 50);
        wait_to(r + 52);

        // BOUNCE via two back-to-back distinct keys.
        do_reset("reset2", r);
        wait_to(r + 1); key_code = 8'h15; push(2'd1, 4'b1000, r + 2);
        wait_to(r + 3); key_code = 8'h16; push(2'd2, 4'b1000, r + 4);
        push(2'd2, 4'b0100, r + 12);
        push(2'd2, 4'b0010, r + 20);
        push(2'd2, 4'b0001, r + 28);
        push(2'd2, 4'b0010, r + 36);
        push(2'd2, 4'b0100, r + 44);
        push(2'd2, 4'b1000, r + 52);
        push(2'd2, 4'b0100, r + 60);
        wait_to(r + 62);

        // Mode wraps 3 -> 0, then speed 2 stepping every 2 cycles.
        c = cyc;
        key_code = 8'h17; push(2'd3, 4'b1000, c + 1);
        wait_to(c + 2); key_code = 8'h18; push(2'd0, 4'b1000, c + 3);
        wait_to(c + 3); speed = 2'd2;
        push(2'd0, 4'b0100, c + 5);
        push(2'd0, 4'b0010, c + 7);
        push(2'd0, 4'b0001, c + 9);
        push(2'd0, 4'b1000, c + 11);
        // Key event lands on the same edge as a tick: restart, no step.
        wait_to(c + 12); key_code = 8'h19; push(2'd1, 4'b1000, c + 13);
        push(2'd1, 4'b0001, c + 15);
        push(2'd1, 4'b0010, c + 17);
        wait_to(c + 18);

        // Reset mid-operation, then a speed change past the new terminal count.
        speed = 2'd0;
        do_reset("reset3", r);
        wait_to(r + 5); speed = 2'd2;
        push(2'd0, 4'b0100, r + 6);
        push(2'd0, 4'b0010, r + 8);
        push(2'd0, 4'b0001, r + 10);
        wait_to(r + 10); speed = 2'd0;
        wait_to(r + 13);

        check_drained("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
